// File: rtl/exu_sequencer.sv
// Issues one multi-cycle op to the mult/div/CLZ unit, waits for it to finish,
// and returns a one-cycle writeback/done pulse to the controller.
module exu_sequencer #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned BUSY_TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [2:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              req_ready,
  output logic              busy,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              mult_start,
  output logic              mult_signed,
  input  logic              mult_busy,
  input  logic [DATA_W-1:0] mult_hi,
  input  logic [DATA_W-1:0] mult_lo,
  output logic              div_start,
  output logic              div_signed,
  input  logic              div_busy,
  input  logic [DATA_W-1:0] div_q,
  input  logic [DATA_W-1:0] div_r,
  output logic              clz_start,
  input  logic              clz_busy,
  input  logic [DATA_W-1:0] clz_ans,
  output logic              hi_we,
  output logic              lo_we,
  output logic [DATA_W-1:0] hi_wdata,
  output logic [DATA_W-1:0] lo_wdata,
  output logic              gr_we,
  output logic [DATA_W-1:0] gr_wdata,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_CLZ   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_ARM,
    S_WAIT,
    S_WB
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  res_hi_q, res_hi_d, res_lo_q, res_lo_d, res_gr_q, res_gr_d;
  logic               err_flag_q, err_flag_d, wr_flag_q, wr_flag_d;

  logic req_ready_q, req_ready_d, busy_q, busy_d;
  logic mult_start_q, mult_start_d, div_start_q, div_start_d, clz_start_q, clz_start_d;
  logic mult_signed_q, mult_signed_d, div_signed_q, div_signed_d;
  logic hi_we_q, hi_we_d, lo_we_q, lo_we_d, gr_we_q, gr_we_d;
  logic done_q, done_d, err_q, err_d;

  logic sel_busy_c;
  logic is_mult_c, is_div_c, is_clz_c;

  // Only the selected unit's busy matters; the others may be in any state.
  always_comb begin
    sel_busy_c = 1'b0;
    case (op_q)
      OP_MULT, OP_MULTU: sel_busy_c = mult_busy;
      OP_DIV,  OP_DIVU:  sel_busy_c = div_busy;
      OP_CLZ:            sel_busy_c = clz_busy;
      default:           sel_busy_c = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    res_hi_d   = res_hi_q;
    res_lo_d   = res_lo_q;
    res_gr_d   = res_gr_q;
    err_flag_d = err_flag_q;
    wr_flag_d  = wr_flag_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          op_d = req_op;
          a_d  = req_a;
          b_d  = req_b;
          if (req_op > OP_CLZ) begin
            err_flag_d = 1'b1;
            wr_flag_d  = 1'b0;
            state_d    = S_WB;
          end else if (((req_op == OP_DIV) || (req_op == OP_DIVU)) && (req_b == '0)) begin
            // Divide by zero completes silently without touching the divider.
            err_flag_d = 1'b0;
            wr_flag_d  = 1'b0;
            state_d    = S_WB;
          end else begin
            err_flag_d = 1'b0;
            wr_flag_d  = 1'b1;
            state_d    = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: state_d = S_ARM;
      S_ARM: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!sel_busy_c) begin
          case (op_q)
            OP_MULT, OP_MULTU: begin
              res_hi_d = mult_hi;
              res_lo_d = mult_lo;
            end
            OP_DIV, OP_DIVU: begin
              res_hi_d = div_r;
              res_lo_d = div_q;
            end
            default: res_gr_d = clz_ans;
          endcase
          state_d = S_WB;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          err_flag_d = 1'b1;
          wr_flag_d  = 1'b0;
          state_d    = S_WB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q.
  always_comb begin
    is_mult_c     = (op_d == OP_MULT) || (op_d == OP_MULTU);
    is_div_c      = (op_d == OP_DIV) || (op_d == OP_DIVU);
    is_clz_c      = (op_d == OP_CLZ);
    req_ready_d   = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    mult_start_d  = (state_d == S_LAUNCH) && is_mult_c;
    div_start_d   = (state_d == S_LAUNCH) && is_div_c;
    clz_start_d   = (state_d == S_LAUNCH) && is_clz_c;
    mult_signed_d = (state_d != S_IDLE) && (op_d == OP_MULT);
    div_signed_d  = (state_d != S_IDLE) && (op_d == OP_DIV);
    done_d        = (state_d == S_WB);
    err_d         = (state_d == S_WB) && err_flag_d;
    hi_we_d       = (state_d == S_WB) && wr_flag_d && (is_mult_c || is_div_c);
    lo_we_d       = hi_we_d;
    gr_we_d       = (state_d == S_WB) && wr_flag_d && is_clz_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      cnt_q         <= '0;
      res_hi_q      <= '0;
      res_lo_q      <= '0;
      res_gr_q      <= '0;
      err_flag_q    <= 1'b0;
      wr_flag_q     <= 1'b0;
      req_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      mult_start_q  <= 1'b0;
      div_start_q   <= 1'b0;
      clz_start_q   <= 1'b0;
      mult_signed_q <= 1'b0;
      div_signed_q  <= 1'b0;
      hi_we_q       <= 1'b0;
      lo_we_q       <= 1'b0;
      gr_we_q       <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      cnt_q         <= cnt_d;
      res_hi_q      <= res_hi_d;
      res_lo_q      <= res_lo_d;
      res_gr_q      <= res_gr_d;
      err_flag_q    <= err_flag_d;
      wr_flag_q     <= wr_flag_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      mult_start_q  <= mult_start_d;
      div_start_q   <= div_start_d;
      clz_start_q   <= clz_start_d;
      mult_signed_q <= mult_signed_d;
      div_signed_q  <= div_signed_d;
      hi_we_q       <= hi_we_d;
      lo_we_q       <= lo_we_d;
      gr_we_q       <= gr_we_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign op_a        = a_q;
  assign op_b        = b_q;
  assign mult_start  = mult_start_q;
  assign mult_signed = mult_signed_q;
  assign div_start   = div_start_q;
  assign div_signed  = div_signed_q;
  assign clz_start   = clz_start_q;
  assign hi_we       = hi_we_q;
  assign lo_we       = lo_we_q;
  assign hi_wdata    = res_hi_q;
  assign lo_wdata    = res_lo_q;
  assign gr_we       = gr_we_q;
  assign gr_wdata    = res_gr_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_exu_sequencer.sv
// Scoreboard bench for exu_sequencer with behavioural mult/div/CLZ unit models.
module tb_exu_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned TO = 63;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [2:0]    req_op;
  logic [DW-1:0] req_a, req_b;
  logic          req_ready, busy;
  logic [DW-1:0] op_a, op_b;
  logic          mult_start, mult_signed, mult_busy;
  logic [DW-1:0] mult_hi, mult_lo;
  logic          div_start, div_signed, div_busy;
  logic [DW-1:0] div_q, div_r;
  logic          clz_start, clz_busy;
  logic [DW-1:0] clz_ans;
  logic          hi_we, lo_we, gr_we, done, err;
  logic [DW-1:0] hi_wdata, lo_wdata, gr_wdata;

  exu_sequencer #(.DATA_W(DW), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .busy(busy), .op_a(op_a), .op_b(op_b),
    .mult_start(mult_start), .mult_signed(mult_signed), .mult_busy(mult_busy),
    .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_start(div_start), .div_signed(div_signed), .div_busy(div_busy),
    .div_q(div_q), .div_r(div_r),
    .clz_start(clz_start), .clz_busy(clz_busy), .clz_ans(clz_ans),
    .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .gr_we(gr_we), .gr_wdata(gr_wdata), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          hw, lw, gw, er;
    logic [DW-1:0] hi, lo, gr;
    int            lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Unit models: configurable busy length, results valid from the start edge.
  int   mult_lat = 0, div_lat = 0, clz_lat = 0;
  bit   force_mult_busy = 1'b0;
  int   m_cnt = 0, d_cnt = 0, c_cnt = 0;
  int   n_mult_st = 0, n_div_st = 0, n_clz_st = 0;

  always @(posedge clk) begin
    logic [63:0] xa, xb, p;
    if (mult_start) begin
      xa = mult_signed ? {{32{op_a[31]}}, op_a} : {32'h0, op_a};
      xb = mult_signed ? {{32{op_b[31]}}, op_b} : {32'h0, op_b};
      p  = xa * xb;
      mult_hi <= p[63:32];
      mult_lo <= p[31:0];
      m_cnt   <= mult_lat;
    end else if (m_cnt > 0) m_cnt <= m_cnt - 1;
  end
  assign mult_busy = (m_cnt != 0) || force_mult_busy;

  always @(posedge clk) begin
    logic signed [DW-1:0] sa, sb;
    if (div_start) begin
      sa = op_a;
      sb = op_b;
      if (op_b != 0) begin
        div_q <= div_signed ? DW'(sa / sb) : op_a / op_b;
        div_r <= div_signed ? DW'(sa % sb) : op_a % op_b;
      end
      d_cnt <= div_lat;
    end else if (d_cnt > 0) d_cnt <= d_cnt - 1;
  end
  assign div_busy = (d_cnt != 0);

  always @(posedge clk) begin
    int n;
    if (clz_start) begin
      n = 0;
      for (int i = DW - 1; i >= 0; i--) begin
        if (op_a[i]) break;
        n++;
      end
      clz_ans <= DW'(n);
      c_cnt   <= clz_lat;
    end else if (c_cnt > 0) c_cnt <= c_cnt - 1;
  end
  assign clz_busy = (c_cnt != 0);

  // Cycle/accept bookkeeping and start-pulse counters, sampled before DUT updates.
  int cyc = 0, acc_cyc = 0;
  always @(posedge clk) begin
    cyc++;
    if (req_valid && req_ready) acc_cyc = cyc;
    if (mult_start) n_mult_st++;
    if (div_start)  n_div_st++;
    if (clz_start)  n_clz_st++;
  end

  // Scoreboard: every done pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (!rst && done) begin
      lat = cyc - acc_cyc + 1;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: done=1 with empty scoreboard at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        if ({hi_we, lo_we, gr_we, err} !== {e.hw, e.lw, e.gw, e.er}) begin
          n_bad++;
          $display("FAIL wb_flags: hi/lo/gr_we,err got %b%b%b%b want %b%b%b%b",
                   hi_we, lo_we, gr_we, err, e.hw, e.lw, e.gw, e.er);
        end
        n_cmp++;
        if (lat != e.lat) begin
          n_bad++;
          $display("FAIL latency: got %0d want %0d", lat, e.lat);
        end
        if (e.hw) begin
          n_cmp++;
          if (hi_wdata !== e.hi || lo_wdata !== e.lo) begin
            n_bad++;
            $display("FAIL hilo_data: got %h/%h want %h/%h", hi_wdata, lo_wdata, e.hi, e.lo);
          end
        end
        if (e.gw) begin
          n_cmp++;
          if (gr_wdata !== e.gr) begin
            n_bad++;
            $display("FAIL gr_data: got %h want %h", gr_wdata, e.gr);
          end
        end
      end
    end
  end

  task automatic push(input logic hw, input logic gw, input logic er,
                      input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                      input logic [DW-1:0] gr, input int lat);
    exp_t e;
    e.hw = hw; e.lw = hw; e.gw = gw; e.er = er;
    e.hi = hi; e.lo = lo; e.gr = gr; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic int norm_lat(input int unit_lat);
    return 4 + ((unit_lat > 1) ? unit_lat - 1 : 0);
  endfunction

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({req_ready, busy, done, err, mult_start, div_start, clz_start} !== 7'b1000000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 1000000",
               {req_ready, busy, done, err, mult_start, div_start, clz_start});
    end
    n_cmp++;
    if ({op_a, op_b, hi_wdata, lo_wdata, gr_wdata} !== '0 || {hi_we, lo_we, gr_we} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_data: op_a=%h op_b=%h we=%b%b%b", op_a, op_b, hi_we, lo_we, gr_we);
    end
    rst = 1'b0;
  endtask

  task automatic test_clz;
    int m0, d0, c0;
    bit ok;
    clz_lat = 2;
    m0 = n_mult_st; d0 = n_div_st; c0 = n_clz_st;
    push(1'b0, 1'b1, 1'b0, '0, '0, 32'd8, norm_lat(2));
    drive_req(3'd4, 32'h00FF_FFFF, 32'h1234_5678);
    wait_done(ok);
    n_cmp++;
    if (!ok || (n_clz_st - c0) != 1 || (n_mult_st - m0) != 0 || (n_div_st - d0) != 0) begin
      n_bad++;
      $display("FAIL clz_starts: done=%0d clz=%0d mult=%0d div=%0d want 1/1/0/0",
               ok, n_clz_st - c0, n_mult_st - m0, n_div_st - d0);
    end
    clz_lat = 0;
  endtask

  task automatic test_mult;
    bit ok;
    mult_lat = 0;
    push(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, '0, 4);
    drive_req(3'd0, 32'hFFFF_FFFE, 32'd3);
    @(negedge clk);
    n_cmp++;
    if (mult_signed !== 1'b1 || div_signed !== 1'b0 || op_a !== 32'hFFFF_FFFE || op_b !== 32'd3) begin
      n_bad++;
      $display("FAIL mult_signed: sgn=%b dsgn=%b op_a=%h op_b=%h want 1 0 fffffffe 00000003",
               mult_signed, div_signed, op_a, op_b);
    end
    wait_done(ok);
    n_cmp++;
    if (!ok || mult_signed !== 1'b1) begin
      n_bad++;
      $display("FAIL mult_done: done_seen=%0d mult_signed_at_wb=%b want 1 1", ok, mult_signed);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL done_one_cycle: done=%b ready=%b busy=%b want 0 1 0", done, req_ready, busy);
    end
    mult_lat = 3;
    push(1'b1, 1'b0, 1'b0, 32'h0000_0002, 32'hFFFF_FFFA, '0, norm_lat(3));
    drive_req(3'd1, 32'hFFFF_FFFE, 32'd3);
    @(negedge clk);
    n_cmp++;
    if (mult_signed !== 1'b0) begin
      n_bad++;
      $display("FAIL multu_signed: got %b want 0", mult_signed);
    end
    wait_done(ok);
    mult_lat = 0;
  endtask

  task automatic test_div;
    int d0;
    bit ok;
    div_lat = 3;
    push(1'b1, 1'b0, 1'b0, 32'd1, 32'd3, '0, norm_lat(3));
    drive_req(3'd3, 32'd7, 32'd2);
    wait_done(ok);
    div_lat = 1;
    push(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, '0, norm_lat(1));
    drive_req(3'd2, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk);
    n_cmp++;
    if (div_signed !== 1'b1 || mult_signed !== 1'b0) begin
      n_bad++;
      $display("FAIL div_signed: got %b/%b want 1/0", div_signed, mult_signed);
    end
    wait_done(ok);
    d0 = n_div_st;
    // Divide by zero: skips the unit, done in the first cycle after accept.
    push(1'b0, 1'b0, 1'b0, '0, '0, '0, 1);
    drive_req(3'd3, 32'd7, 32'd0);
    wait_done(ok);
    n_cmp++;
    if (!ok || (n_div_st - d0) != 0) begin
      n_bad++;
      $display("FAIL divzero_start: done_seen=%0d div_starts=%0d want 1 0", ok, n_div_st - d0);
    end
    div_lat = 0;
  endtask

  task automatic test_illegal;
    int s0;
    bit ok;
    for (int op = 5; op <= 7; op++) begin
      s0 = n_mult_st + n_div_st + n_clz_st;
      push(1'b0, 1'b0, 1'b1, '0, '0, '0, 1);
      drive_req(3'(op), 32'hDEAD_BEEF, 32'h1);
      wait_done(ok);
      @(negedge clk);
      n_cmp++;
      if (!ok || (n_mult_st + n_div_st + n_clz_st - s0) != 0 || req_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL illegal_op%0d: done_seen=%0d starts=%0d ready=%b want 1 0 1",
                 op, ok, n_mult_st + n_div_st + n_clz_st - s0, req_ready);
      end
    end
  endtask

  task automatic test_timeout;
    bit ok;
    force_mult_busy = 1'b1;
    push(1'b0, 1'b0, 1'b1, '0, '0, '0, 3 + TO);
    drive_req(3'd0, 32'd5, 32'd6);
    wait_done(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL timeout_done: done never seen within 200 cycles");
    end
    force_mult_busy = 1'b0;
  endtask

  task automatic test_ignore_valid;
    int m0;
    bit ok;
    m0 = n_mult_st;
    mult_lat = 2;
    push(1'b1, 1'b0, 1'b0, 32'd0, 32'd42, '0, norm_lat(2));
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd1; req_a = 32'd6; req_b = 32'd7;
    @(posedge clk);
    #1 req_op = 3'd4;
    wait_done(ok);
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (!ok || (n_mult_st - m0) != 1 || n_clz_st != 1) begin
      n_bad++;
      $display("FAIL ignore_valid: done_seen=%0d mult_starts=%0d clz_total=%0d want 1 1 1",
               ok, n_mult_st - m0, n_clz_st);
    end
    mult_lat = 0;
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] a, b;
    logic [63:0]   p;
    int            lat;
    bit            ok;
    for (int i = 0; i < 8; i++) begin
      a   = $urandom;
      b   = $urandom_range(1, 5000);
      lat = $urandom_range(0, 4);
      if (i % 2 == 0) begin
        mult_lat = lat;
        p = {32'h0, a} * {32'h0, b};
        push(1'b1, 1'b0, 1'b0, p[63:32], p[31:0], '0, norm_lat(lat));
        drive_req(3'd1, a, b);
      end else begin
        div_lat = lat;
        push(1'b1, 1'b0, 1'b0, a % b, a / b, '0, norm_lat(lat));
        drive_req(3'd3, a, b);
      end
      wait_done(ok);
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL b2b_done%0d: done never seen", i);
      end
    end
    mult_lat = 0; div_lat = 0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    force_mult_busy = 1'b1;
    push(1'b0, 1'b0, 1'b1, '0, '0, '0, 0);
    drive_req(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    n_cmp++;
    if ({req_ready, busy, done, err, mult_start, mult_signed, div_signed, hi_we, lo_we, gr_we} !== 10'b1000000000) begin
      n_bad++;
      $display("FAIL reset_mid_ctrl: got %b want 1000000000",
               {req_ready, busy, done, err, mult_start, mult_signed, div_signed, hi_we, lo_we, gr_we});
    end
    n_cmp++;
    if ({op_a, op_b, hi_wdata, lo_wdata, gr_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_data: op_a=%h op_b=%h hi=%h lo=%h want all 0", op_a, op_b, hi_wdata, lo_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_with_busy: ready=%b busy=%b want 1 0 with mult_busy high", req_ready, busy);
    end
    force_mult_busy = 1'b0;
    push(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF6, '0, 4);
    drive_req(3'd0, 32'd5, 32'hFFFF_FFFE);
    wait_done(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL mult_after_reset: done never seen");
    end
  endtask

  initial begin
    test_reset();
    test_clz();
    test_mult();
    test_div();
    test_illegal();
    test_timeout();
    test_ignore_valid();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
